// File: rtl/mux_pipe_reg_if.sv
// Handshake bundle for mux_pipe_reg: upstream offer (data, select, valid,
// flush) and downstream delivery (data, error flag, valid/ready).
interface mux_pipe_reg_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  // Side that drives the mux (upstream producer and downstream consumer).
  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  // The mux stage itself.
  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/mux_pipe_reg.sv
// N-to-1 registered pipeline mux with valid/ready handshake and a one-entry
// skid buffer. Illegal selects are delivered as zero data with out_err set.
module mux_pipe_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input logic           Clk,
  input logic           Rst,
  mux_pipe_reg_if.slave bus
);

  if (NUM_IN < 2 || NUM_IN > 16 || (1 << SEL_W) < NUM_IN) begin : g_bad_params
    $error("mux_pipe_reg: NUM_IN must be 2..16 and 2**SEL_W >= NUM_IN");
  end

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             accept;
  logic             pop;
  logic             load_out;
  logic             out_from_skid;
  logic             load_skid;

  logic [WIDTH-1:0] cap_data;
  logic             cap_err;

  logic [WIDTH-1:0] out_q;
  logic             out_err_q;
  logic [WIDTH-1:0] skid_q;
  logic             skid_err_q;

  // in_ready depends on state only, so no combinational path from out_ready.
  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = out_q;
  assign bus.out_err   = out_err_q;

  // A flush cycle never transfers, even if in_ready reads 1.
  assign accept = bus.in_valid && (state != TWO) && !bus.flush;
  assign pop    = (state != EMPTY) && bus.out_ready;

  // Select the addressed channel; any select without a channel yields zero + err.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        cap_data = bus.in_data[k*WIDTH +: WIDTH];
        cap_err  = 1'b0;
      end
    end
  end

  // Occupancy next-state and register load controls; flush overrides everything.
  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_out  = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_nxt     = ONE;
            load_out      = 1'b1;
            out_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Output register: loads either the freshly captured word or the skid entry.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_q     <= '0;
      out_err_q <= 1'b0;
    end else if (load_out) begin
      out_q     <= out_from_skid ? skid_q     : cap_data;
      out_err_q <= out_from_skid ? skid_err_q : cap_err;
    end
  end

  // Skid register: holds the second entry while the output register is stalled.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else if (load_skid) begin
      skid_q     <= cap_data;
      skid_err_q <= cap_err;
    end
  end

endmodule
